// File: rtl/cc_mim_pkg.sv
// Shared definitions for the ARC control-store address unit: COND encodings,
// field widths, the DECODE address mapping and the memory-wait FSM states.
package cc_mim_pkg;

  localparam int CS_ADDR_W  = 11;
  localparam int COND_W     = 3;
  localparam int IR_W       = 32;
  localparam int NZVC_W     = 4;
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [COND_W-1:0] {
    COND_NEXT   = 3'b000,
    COND_N      = 3'b001,
    COND_Z      = 3'b010,
    COND_V      = 3'b011,
    COND_C      = 3'b100,
    COND_IR13   = 3'b101,
    COND_JUMP   = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // DECODE dispatch: op and op3 fields select one of 256 four-word slots.
  function automatic logic [CS_ADDR_W-1:0] decode_addr(input logic [IR_W-1:0] ir);
    return {1'b1, ir[31:30], ir[24:19], 2'b00};
  endfunction

endpackage

// File: rtl/cc_mim_csai_nextaddr.sv
// Combinational next-address mux: picks microPC+1, the microword's JUMP ADDR,
// or the DECODE dispatch address from the COND field, flags and IR.
module cc_mim_csai_nextaddr
  import cc_mim_pkg::*;
(
  input  logic [COND_W-1:0]    i_cond,
  input  logic [CS_ADDR_W-1:0] i_jump_addr,
  input  logic [CS_ADDR_W-1:0] i_upc,
  input  logic [IR_W-1:0]      i_ir,
  input  logic [NZVC_W-1:0]    i_nzvc,
  output logic [CS_ADDR_W-1:0] o_next_addr
);

  logic [CS_ADDR_W-1:0] w_incr;
  logic                 w_taken;
  logic                 w_unused_ir;

  // Natural 11-bit overflow gives the 2047 -> 0 wrap.
  assign w_incr      = i_upc + 1'b1;
  assign w_unused_ir = ^{i_ir[29:25], i_ir[18:14], i_ir[12:0]};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_taken     = 1'b0;
    o_next_addr = w_incr;
    unique case (cond_e'(i_cond))
      COND_NEXT:   w_taken = 1'b0;
      COND_N:      w_taken = i_nzvc[3];
      COND_Z:      w_taken = i_nzvc[2];
      COND_V:      w_taken = i_nzvc[1];
      COND_C:      w_taken = i_nzvc[0];
      COND_IR13:   w_taken = i_ir[13];
      COND_JUMP:   w_taken = 1'b1;
      COND_DECODE: w_taken = 1'b0;
      default:     w_taken = 1'b0;
    endcase
    if (cond_e'(i_cond) == COND_DECODE) begin
      o_next_addr = decode_addr(i_ir);
    end else if (w_taken) begin
      o_next_addr = i_jump_addr;
    end
  end

endmodule

// File: rtl/cc_mim_csai.sv
// CSAI top: microPC register, memory-wait FSM, wait counter and sticky timeout.
// Memory-wait stall/timeout logic is present only with CC_MIM_CSAI_MEMWAIT_EN.
module cc_mim_csai
  import cc_mim_pkg::*;
#(
  parameter int                   MEM_TIMEOUT = 16,
  parameter logic [CS_ADDR_W-1:0] TRAP_ADDR   = 11'd2047
) (
  input  logic                 CC_MIM_CSAI_CLOCK_50,
  input  logic                 CC_MIM_CSAI_RESET_InHigh,
  input  logic [COND_W-1:0]    CC_MIM_CSAI_cond_InBUS,
  input  logic [CS_ADDR_W-1:0] CC_MIM_CSAI_jumpaddr_InBUS,
  input  logic                 CC_MIM_CSAI_rd_In,
  input  logic                 CC_MIM_CSAI_wr_In,
  input  logic [IR_W-1:0]      CC_MIM_CSAI_ir_InBUS,
  input  logic [NZVC_W-1:0]    CC_MIM_CSAI_nzvc_InBUS,
  input  logic                 CC_MIM_CSAI_memready_In,
  output logic [CS_ADDR_W-1:0] CC_MIM_CSAI_data_OutBUS,
  output logic                 CC_MIM_CSAI_stall_Out,
  output logic                 CC_MIM_CSAI_timeout_Out
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [CS_ADDR_W-1:0]  r_upc;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_timeout;
  logic [CS_ADDR_W-1:0]  w_next_addr;
  logic                  w_mem_busy;
  logic                  w_mem_ready;
  logic                  w_cnt_limit;
  logic                  w_hold;
  logic                  w_trap;

`ifdef CC_MIM_CSAI_MEMWAIT_EN
  assign w_mem_busy  = (CC_MIM_CSAI_rd_In | CC_MIM_CSAI_wr_In) & ~CC_MIM_CSAI_memready_In;
  assign w_mem_ready = CC_MIM_CSAI_memready_In;
`else
  logic w_unused_memwait;
  // Without the wait option memory always looks ready, so the FSM never leaves RUN.
  assign w_unused_memwait = CC_MIM_CSAI_rd_In | CC_MIM_CSAI_wr_In | CC_MIM_CSAI_memready_In;
  assign w_mem_busy       = 1'b0;
  assign w_mem_ready      = 1'b1;
`endif

  assign w_cnt_limit = (r_wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT - 1));

  cc_mim_csai_nextaddr u_nextaddr (
    .i_cond      (CC_MIM_CSAI_cond_InBUS),
    .i_jump_addr (CC_MIM_CSAI_jumpaddr_InBUS),
    .i_upc       (r_upc),
    .i_ir        (CC_MIM_CSAI_ir_InBUS),
    .i_nzvc      (CC_MIM_CSAI_nzvc_InBUS),
    .o_next_addr (w_next_addr)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CC_MIM_CSAI_CLOCK_50) begin
    if (CC_MIM_CSAI_RESET_InHigh) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:  if (w_mem_busy) w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_mem_ready || w_cnt_limit) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // The RUN cycle that raises the request already counts as the first stalled cycle.
  always_comb begin
    w_hold = 1'b0;
    w_trap = 1'b0;
    unique case (r_state)
      ST_RUN:  w_hold = w_mem_busy;
      ST_WAIT: begin
        w_hold = ~w_mem_ready & ~w_cnt_limit;
        w_trap = ~w_mem_ready &  w_cnt_limit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CC_MIM_CSAI_CLOCK_50) begin
    if (CC_MIM_CSAI_RESET_InHigh) begin
      r_upc      <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_trap) begin
        r_upc     <= TRAP_ADDR;
        r_timeout <= 1'b1;
      end else if (!w_hold) begin
        r_upc <= w_next_addr;
      end
      r_wait_cnt <= w_hold ? r_wait_cnt + 1'b1 : '0;
    end
  end

  assign CC_MIM_CSAI_data_OutBUS = r_upc;
  assign CC_MIM_CSAI_stall_Out   = w_mem_busy & ~CC_MIM_CSAI_RESET_InHigh;
  assign CC_MIM_CSAI_timeout_Out = r_timeout;

endmodule

// File: tb/tb_cc_mim_csai.sv
// Self-checking bench for cc_mim_csai: directed cases then random microwords
// checked against an arithmetic reference model (honours CC_MIM_CSAI_MEMWAIT_EN).
module tb_cc_mim_csai;

  localparam int MEM_TIMEOUT = 16;
  localparam int TRAP_ADDR   = 2047;
`ifdef CC_MIM_CSAI_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cond;
  logic [10:0] jaddr;
  logic        rd, wr;
  logic [31:0] ir;
  logic [3:0]  nzvc;
  logic        memready;
  logic [10:0] addr_o;
  logic        stall_o;
  logic        tmo_o;

  int total = 0;
  int bad   = 0;

  // Reference state: current microPC, sticky flag, stalled cycles so far.
  int exp_pc    = 0;
  bit exp_tmo   = 1'b0;
  int n_stalled = 0;

  always #5 clk = ~clk;

  cc_mim_csai #(.MEM_TIMEOUT(MEM_TIMEOUT), .TRAP_ADDR(11'd2047)) dut (
    .CC_MIM_CSAI_CLOCK_50       (clk),
    .CC_MIM_CSAI_RESET_InHigh   (rst),
    .CC_MIM_CSAI_cond_InBUS     (cond),
    .CC_MIM_CSAI_jumpaddr_InBUS (jaddr),
    .CC_MIM_CSAI_rd_In          (rd),
    .CC_MIM_CSAI_wr_In          (wr),
    .CC_MIM_CSAI_ir_InBUS       (ir),
    .CC_MIM_CSAI_nzvc_InBUS     (nzvc),
    .CC_MIM_CSAI_memready_In    (memready),
    .CC_MIM_CSAI_data_OutBUS    (addr_o),
    .CC_MIM_CSAI_stall_Out      (stall_o),
    .CC_MIM_CSAI_timeout_Out    (tmo_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(int pc, int c, int ja, logic [31:0] irv, logic [3:0] f);
    bit taken;
    case (c)
      1:       taken = f[3];
      2:       taken = f[2];
      3:       taken = f[1];
      4:       taken = f[0];
      5:       taken = irv[13];
      6:       taken = 1'b1;
      7:       return 1024 + int'(irv[31:30]) * 256 + int'(irv[24:19]) * 4;
      default: taken = 1'b0;
    endcase
    return taken ? ja : (pc + 1) % 2048;
  endfunction

  // One microword per call: drive at negedge, check stall mid-cycle, check state after the edge.
  task automatic cycle(input logic [2:0] c, input logic [10:0] ja, input logic rdv, input logic wrv,
                       input logic [31:0] irv, input logic [3:0] f, input logic mr, input logic rs);
    bit busy;
    @(negedge clk);
    cond = c; jaddr = ja; rd = rdv; wr = wrv; ir = irv; nzvc = f; memready = mr; rst = rs;
    busy = MEMWAIT && (rdv || wrv) && !mr;
    #1;
    check("stall", 32'(stall_o), 32'(busy && !rs));
    @(posedge clk);
    if (rs) begin
      exp_pc = 0; exp_tmo = 1'b0; n_stalled = 0;
    end else if (busy) begin
      n_stalled++;
      if (n_stalled == MEM_TIMEOUT) begin
        exp_pc = TRAP_ADDR; exp_tmo = 1'b1; n_stalled = 0;
      end
    end else begin
      exp_pc = model_next(exp_pc, int'(c), int'(ja), irv, f);
      n_stalled = 0;
    end
    #1;
    check("addr", 32'(addr_o), 32'(exp_pc));
    check("timeout", 32'(tmo_o), 32'(exp_tmo));
  endtask

  task automatic seq(input logic [2:0] c, input logic [10:0] ja);
    cycle(c, ja, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
  endtask

  initial begin
    int held;
    logic [2:0]  rc;
    logic [10:0] rj;
    logic        rrd, rwr;
    logic [31:0] rir;
    logic [3:0]  rf;
    logic        rmr, rrs;
    bit          slow;

    rst = 1'b1; cond = '0; jaddr = '0; rd = 1'b0; wr = 1'b0; ir = '0; nzvc = '0; memready = 1'b1;

    cycle(3'b000, 11'd0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
    check("reset_addr", 32'(addr_o), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      seq(3'b000, 11'd0);
      check("incr_seq", 32'(addr_o), 32'(i));
    end
    seq(3'b110, 11'd2047);
    seq(3'b000, 11'd0);
    check("wrap", 32'(addr_o), 32'd0);

    seq(3'b110, 11'd5);
    cycle(3'b010, 11'd12, 1'b0, 1'b0, 32'h0, 4'b0100, 1'b1, 1'b0);
    check("z_taken", 32'(addr_o), 32'd12);
    seq(3'b110, 11'd5);
    cycle(3'b010, 11'd12, 1'b0, 1'b0, 32'h0, 4'b1011, 1'b1, 1'b0);
    check("z_not_taken", 32'(addr_o), 32'd6);

    cycle(3'b111, 11'd0, 1'b0, 1'b0, 32'h8280_0000, 4'h0, 1'b1, 1'b0);
    check("decode_addcc", 32'(addr_o), 32'd1600);
    cycle(3'b101, 11'd1603, 1'b0, 1'b0, 32'h0000_2000, 4'h0, 1'b1, 1'b0);
    check("ir13_taken", 32'(addr_o), 32'd1603);

`ifdef CC_MIM_CSAI_MEMWAIT_EN
    held = exp_pc;
    for (int i = 0; i < 3; i++) begin
      cycle(3'b000, 11'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      check("rd_stall_out", 32'(stall_o), 32'd1);
      check("rd_hold", 32'(addr_o), 32'(held));
    end
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    check("rd_advance", 32'(addr_o), 32'((held + 1) % 2048));
    check("rd_no_tmo", 32'(tmo_o), 32'd0);

    seq(3'b110, 11'd100);
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      cycle(3'b000, 11'd0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
      if (i == MEM_TIMEOUT - 2) check("wr_hold_15", 32'(addr_o), 32'd100);
    end
    check("trap_addr", 32'(addr_o), 32'd2047);
    check("trap_flag", 32'(tmo_o), 32'd1);
    for (int i = 0; i < 4; i++) seq(3'b000, 11'd0);
    check("tmo_sticky", 32'(tmo_o), 32'd1);

    cycle(3'b000, 11'd0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1);
    seq(3'b110, 11'd200);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++)
      cycle(3'b000, 11'd0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b0, 1'b0);
    cycle(3'b000, 11'd0, 1'b0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0);
    check("ready_wins", 32'(addr_o), 32'd201);
    check("ready_no_tmo", 32'(tmo_o), 32'd0);

    for (int i = 0; i < 2; i++)
      cycle(3'b000, 11'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    check("rst_in_wait_addr", 32'(addr_o), 32'd0);
    check("rst_in_wait_tmo", 32'(tmo_o), 32'd0);
`else
    held = exp_pc;
    cycle(3'b000, 11'd0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    check("no_memwait_adv", 32'(addr_o), 32'((held + 1) % 2048));
    check("no_memwait_stall", 32'(stall_o), 32'd0);
`endif

    // Random microwords; a stalled word stays on the bus until memory answers or traps.
    slow = 1'b0;
    rc = '0; rj = '0; rrd = 1'b0; rwr = 1'b0; rir = '0; rf = '0;
    for (int n = 0; n < 600; n++) begin
      if (n % 100 == 0) slow = ~slow;
      if (n_stalled == 0) begin
        rc  = 3'($urandom_range(0, 7));
        rj  = 11'($urandom_range(0, 2047));
        rir = $urandom;
        rf  = 4'($urandom_range(0, 15));
        rrd = ($urandom_range(0, 9) < 2);
        rwr = ($urandom_range(0, 9) < 2);
      end
      rmr = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
      rrs = ($urandom_range(0, 149) == 0);
      cycle(rc, rj, rrd, rwr, rir, rf, rmr, rrs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
